// File: rtl/pipe_hazard_sched_if.sv
// Bundle of hazard inputs and per-stage stall/clear requests exchanged between
// the pipeline control unit (master) and the hazard scheduler (slave).
interface pipe_hazard_sched_if #(
    parameter int LAT_W = 4
);
    // Unit enable
    logic             ACT;

    // Hazard sources
    logic             wb_flush;
    logic             ex_redirect;
    logic             ex_redirect_slot;
    logic             dmem_busy;
    logic             ex_mc_start;
    logic [LAT_W-1:0] ex_mc_lat;
    logic             id_load_use;

    // Stage stall requests
    logic             s_if_stall;
    logic             s_id1_stall;
    logic             s_id2_stall;
    logic             s_ex1_stall;
    logic             s_ex2_stall;
    logic             s_me1_stall;
    logic             s_me2_stall;
    logic             s_wb1_stall;
    logic             s_wb2_stall;

    // Stage clear (bubble) requests
    logic             s_id_clear;
    logic             s_ex1_clear;
    logic             s_ex2_clear;
    logic             s_me1_clear;
    logic             s_me2_clear;
    logic             s_wb1_clear;
    logic             s_wb2_clear;

    logic             sched_busy;

    // Control-unit side: raises hazards, consumes stall/clear requests
    modport master (
        output ACT, wb_flush, ex_redirect, ex_redirect_slot, dmem_busy,
               ex_mc_start, ex_mc_lat, id_load_use,
        input  s_if_stall, s_id1_stall, s_id2_stall, s_ex1_stall, s_ex2_stall,
               s_me1_stall, s_me2_stall, s_wb1_stall, s_wb2_stall,
               s_id_clear, s_ex1_clear, s_ex2_clear, s_me1_clear, s_me2_clear,
               s_wb1_clear, s_wb2_clear, sched_busy
    );

    // Scheduler side
    modport slave (
        input  ACT, wb_flush, ex_redirect, ex_redirect_slot, dmem_busy,
               ex_mc_start, ex_mc_lat, id_load_use,
        output s_if_stall, s_id1_stall, s_id2_stall, s_ex1_stall, s_ex2_stall,
               s_me1_stall, s_me2_stall, s_wb1_stall, s_wb2_stall,
               s_id_clear, s_ex1_clear, s_ex2_clear, s_me1_clear, s_me2_clear,
               s_wb1_clear, s_wb2_clear, sched_busy
    );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Hazard scheduler for the dual-issue pipeline (IF, ID1/2, EX1/2, ME1/2, WB1/2).
// Arbitrates trap flush, branch redirect, data-memory wait, multi-cycle EX ops
// and load-use hazards by fixed priority and emits per-stage stall/clear
// requests. Multi-cycle cases are sequenced by a small FSM with two counters.
//
// Stall requests are expressed as a "stall level": every stage group up to and
// including that level is stalled, and the first group after it is cleared so a
// bubble enters behind the frozen stages. Groups: 0=IF, 1=ID, 2=EX, 3=ME, 4=WB.
module pipe_hazard_sched #(
    parameter int FLUSH_CYCLES = 2,
    parameter int LAT_W        = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    pipe_hazard_sched_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    // Stall levels: how deep the frozen region extends
    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_ID   = 2'd1;   // load-use
    localparam logic [1:0] LVL_EX   = 2'd2;   // multi-cycle EX op
    localparam logic [1:0] LVL_ME   = 2'd3;   // data memory wait

    // Flush-counter reload: the flush cycle itself is one of FLUSH_CYCLES
    localparam logic [3:0]       FL_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0]       FL_ONE    = 4'd1;
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_TWO   = LAT_W'(2);

    state_t           state_reg;
    logic [LAT_W-1:0] mc_cnt_reg;
    logic [3:0]       fl_cnt_reg;

    logic             op_en;
    logic             mc_long;
    logic [1:0]       stall_lvl;
    logic             clr_all;
    logic             clr_id;
    logic             clr_me2;
    logic [8:0]       stall_vec;   // [0]=IF .. [8]=WB2
    logic [6:0]       clear_vec;   // [0]=ID .. [6]=WB2

    // Outputs are suppressed while disabled or while reset is held
    assign op_en   = bus.ACT && RST_N;
    // Latency 0/1 ops finish in their entry cycle and need no stall
    assign mc_long = bus.ex_mc_start && (bus.ex_mc_lat >= LAT_TWO);

    // State sequencing: the wait counters hold the number of extra cycles
    // still to spend in MC_WAIT / FLUSH, so the state is left when the counter
    // would step from 1 to 0. A latency-2 op or FLUSH_CYCLES=1 therefore
    // never leaves RUN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= RUN;
            mc_cnt_reg <= '0;
            fl_cnt_reg <= '0;
        end else if (bus.ACT) begin
            case (state_reg)
                RUN: begin
                    if (bus.wb_flush) begin
                        if (FLUSH_CYCLES > 1) begin
                            state_reg  <= FLUSH;
                            fl_cnt_reg <= FL_RELOAD;
                        end
                    end else if (bus.ex_redirect || bus.dmem_busy) begin
                        // single-cycle patterns, no sequencing needed
                        state_reg <= RUN;
                    end else if (mc_long && (bus.ex_mc_lat > LAT_TWO)) begin
                        state_reg  <= MC_WAIT;
                        mc_cnt_reg <= bus.ex_mc_lat - LAT_TWO;
                    end
                end

                MC_WAIT: begin
                    if (bus.wb_flush) begin
                        // trap aborts the multi-cycle op
                        mc_cnt_reg <= '0;
                        if (FLUSH_CYCLES > 1) begin
                            state_reg  <= FLUSH;
                            fl_cnt_reg <= FL_RELOAD;
                        end else begin
                            state_reg <= RUN;
                        end
                    end else if (!bus.dmem_busy) begin
                        // the EX op only makes progress while ME is not blocked
                        if (mc_cnt_reg <= LAT_ONE) begin
                            state_reg  <= RUN;
                            mc_cnt_reg <= '0;
                        end else begin
                            mc_cnt_reg <= mc_cnt_reg - LAT_ONE;
                        end
                    end
                end

                FLUSH: begin
                    if (bus.wb_flush) begin
                        // back-to-back trap restarts the flush window
                        if (FLUSH_CYCLES > 1) begin
                            fl_cnt_reg <= FL_RELOAD;
                        end else begin
                            state_reg  <= RUN;
                            fl_cnt_reg <= '0;
                        end
                    end else if (fl_cnt_reg <= FL_ONE) begin
                        state_reg  <= RUN;
                        fl_cnt_reg <= '0;
                    end else begin
                        fl_cnt_reg <= fl_cnt_reg - FL_ONE;
                    end
                end

                default: begin
                    state_reg  <= RUN;
                    mc_cnt_reg <= '0;
                    fl_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Priority arbitration of the hazard sources into a stall level plus
    // the special clear patterns of flush and redirect
    always_comb begin
        stall_lvl = LVL_NONE;
        clr_all   = 1'b0;
        clr_id    = 1'b0;
        clr_me2   = 1'b0;
        if (op_en) begin
            case (state_reg)
                RUN: begin
                    if (bus.wb_flush) begin
                        clr_all = 1'b1;
                    end else if (bus.ex_redirect) begin
                        // wrong-path fetch in ID dies; a lane-1 branch also
                        // kills its lane-2 partner now leaving EX
                        clr_id  = 1'b1;
                        clr_me2 = !bus.ex_redirect_slot;
                    end else if (bus.dmem_busy) begin
                        stall_lvl = LVL_ME;
                    end else if (mc_long) begin
                        stall_lvl = LVL_EX;
                    end else if (bus.id_load_use) begin
                        stall_lvl = LVL_ID;
                    end
                end
                MC_WAIT: begin
                    // redirect/load-use/mc_start cannot arise while EX is frozen
                    if (bus.wb_flush) begin
                        clr_all = 1'b1;
                    end else if (bus.dmem_busy) begin
                        stall_lvl = LVL_ME;
                    end else begin
                        stall_lvl = LVL_EX;
                    end
                end
                FLUSH: begin
                    clr_all = 1'b1;
                end
                default: begin
                    clr_all = 1'b0;
                end
            endcase
        end
    end

    // Stage i belongs to group (i+1)/2: IF alone, then lane pairs.
    // Every stage at or before the stall level is held.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_stall
            localparam int GRP = (gi + 1) / 2;
            assign stall_vec[gi] = (stall_lvl != LVL_NONE) && (GRP <= int'(stall_lvl));
        end
    endgenerate

    // Clear i belongs to group (i+3)/2: ID, then EX/ME/WB pairs. The group just
    // past the stall level receives the bubble; flush and redirect add theirs.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_clear
            localparam int CGRP = (gi + 3) / 2;
            logic extra;
            if (gi == 0) begin : g_id
                assign extra = clr_id;
            end else if (gi == 4) begin : g_me2
                assign extra = clr_me2;
            end else begin : g_none
                assign extra = 1'b0;
            end
            assign clear_vec[gi] = clr_all || extra ||
                ((stall_lvl != LVL_NONE) && (CGRP == int'(stall_lvl) + 1));
        end
    endgenerate

    assign bus.s_if_stall  = stall_vec[0];
    assign bus.s_id1_stall = stall_vec[1];
    assign bus.s_id2_stall = stall_vec[2];
    assign bus.s_ex1_stall = stall_vec[3];
    assign bus.s_ex2_stall = stall_vec[4];
    assign bus.s_me1_stall = stall_vec[5];
    assign bus.s_me2_stall = stall_vec[6];
    assign bus.s_wb1_stall = stall_vec[7];
    assign bus.s_wb2_stall = stall_vec[8];

    assign bus.s_id_clear  = clear_vec[0];
    assign bus.s_ex1_clear = clear_vec[1];
    assign bus.s_ex2_clear = clear_vec[2];
    assign bus.s_me1_clear = clear_vec[3];
    assign bus.s_me2_clear = clear_vec[4];
    assign bus.s_wb1_clear = clear_vec[5];
    assign bus.s_wb2_clear = clear_vec[6];

    assign bus.sched_busy  = op_en && (state_reg != RUN);

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Scoreboard bench for pipe_hazard_sched: a stimulus process drives one
// transaction per cycle and queues the expected output word from a
// remaining-cycles reference model; a negedge monitor pops and compares.
module tb_pipe_hazard_sched;

    localparam int FLC = 2;
    localparam int LW  = 4;

    // Expected patterns; stall bits IF,ID1,ID2,EX1,EX2,ME1,ME2,WB1,WB2 (MSB first),
    // clear bits ID,EX1,EX2,ME1,ME2,WB1,WB2 (MSB first)
    localparam logic [8:0] ST_LU  = 9'b111000000;
    localparam logic [8:0] ST_MC  = 9'b111110000;
    localparam logic [8:0] ST_DM  = 9'b111111100;
    localparam logic [6:0] CL_LU  = 7'b0110000;
    localparam logic [6:0] CL_MC  = 7'b0001100;
    localparam logic [6:0] CL_DM  = 7'b0000011;
    localparam logic [6:0] CL_ALL = 7'b1111111;
    localparam logic [6:0] CL_RD0 = 7'b1000100;
    localparam logic [6:0] CL_RD1 = 7'b1000000;

    typedef struct {
        logic [16:0] exp;
        string       tag;
    } item_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    pipe_hazard_sched_if #(.LAT_W(LW)) bus ();

    pipe_hazard_sched #(.FLUSH_CYCLES(FLC), .LAT_W(LW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    item_t sbq[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model: extra cycles still owed to a flush window / multi-cycle op
    int fl_left = 0;
    int mc_left = 0;

    function automatic logic [16:0] model_step(input logic act, input logic wbf,
                                               input logic red, input logic slot,
                                               input logic dm, input logic mcs,
                                               input int lat, input logic lu);
        logic [8:0] st;
        logic [6:0] cl;
        logic       bz;
        st = '0;
        cl = '0;
        bz = 1'b0;
        if (!act) return '0;
        bz = (fl_left > 0) || (mc_left > 0);
        if (fl_left > 0) begin
            cl = CL_ALL;
            fl_left = wbf ? FLC - 1 : fl_left - 1;
        end else if (mc_left > 0) begin
            if (wbf) begin
                cl = CL_ALL;
                mc_left = 0;
                fl_left = FLC - 1;
            end else if (dm) begin
                st = ST_DM; cl = CL_DM;
            end else begin
                st = ST_MC; cl = CL_MC;
                mc_left = mc_left - 1;
            end
        end else begin
            if (wbf) begin
                cl = CL_ALL;
                fl_left = FLC - 1;
            end else if (red) begin
                cl = slot ? CL_RD1 : CL_RD0;
            end else if (dm) begin
                st = ST_DM; cl = CL_DM;
            end else if (mcs && lat >= 2) begin
                st = ST_MC; cl = CL_MC;
                mc_left = lat - 2;
            end else if (lu) begin
                st = ST_LU; cl = CL_LU;
            end
        end
        return {st, cl, bz};
    endfunction

    function automatic logic [16:0] dut_word();
        return {bus.s_if_stall, bus.s_id1_stall, bus.s_id2_stall,
                bus.s_ex1_stall, bus.s_ex2_stall, bus.s_me1_stall,
                bus.s_me2_stall, bus.s_wb1_stall, bus.s_wb2_stall,
                bus.s_id_clear, bus.s_ex1_clear, bus.s_ex2_clear,
                bus.s_me1_clear, bus.s_me2_clear, bus.s_wb1_clear,
                bus.s_wb2_clear, bus.sched_busy};
    endfunction

    // One clock of stimulus; expected word goes to the scoreboard
    task automatic cyc(input logic act, input logic wbf, input logic red,
                       input logic slot, input logic dm, input logic mcs,
                       input int lat, input logic lu, input string tag);
        item_t it;
        @(posedge CLK);
        #1;
        RST_N                = 1'b1;
        bus.ACT              = act;
        bus.wb_flush         = wbf;
        bus.ex_redirect      = red;
        bus.ex_redirect_slot = slot;
        bus.dmem_busy        = dm;
        bus.ex_mc_start      = mcs;
        bus.ex_mc_lat        = LW'(lat);
        bus.id_load_use      = lu;
        it.exp = model_step(act, wbf, red, slot, dm, mcs, lat, lu);
        it.tag = tag;
        sbq.push_back(it);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Reset asserted between edges with a live hazard present: outputs must be 0
    task automatic rst_cyc(input string tag);
        item_t it;
        @(posedge CLK);
        #1;
        RST_N           = 1'b0;
        bus.ACT         = 1'b1;
        bus.wb_flush    = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.dmem_busy   = 1'b0;
        bus.ex_mc_start = 1'b0;
        bus.id_load_use = 1'b1;
        fl_left = 0;
        mc_left = 0;
        it.exp = '0;
        it.tag = tag;
        sbq.push_back(it);
    endtask

    // Monitor: compare one queued expectation per cycle, away from the edge
    always @(negedge CLK) begin : monitor
        item_t       it;
        logic [16:0] got;
        if (sbq.size() > 0) begin
            it  = sbq.pop_front();
            got = dut_word();
            n_checks++;
            if (got === it.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s got=%05h want=%05h t=%0t", it.tag, got, it.exp, $time);
            end
        end
    end

    initial begin
        bus.ACT              = 1'b0;
        bus.wb_flush         = 1'b0;
        bus.ex_redirect      = 1'b0;
        bus.ex_redirect_slot = 1'b0;
        bus.dmem_busy        = 1'b0;
        bus.ex_mc_start      = 1'b0;
        bus.ex_mc_lat        = '0;
        bus.id_load_use      = 1'b0;

        rst_cyc("reset");
        rst_cyc("reset");
        idle(5, "idle_after_reset");

        cyc(1, 0, 0, 0, 0, 0, 0, 1, "load_use");
        idle(1, "load_use_after");

        cyc(1, 0, 0, 0, 0, 1, 4, 0, "mc_lat4_start");
        idle(4, "mc_lat4_wait");
        cyc(1, 0, 0, 0, 0, 1, 1, 0, "mc_lat1");
        cyc(1, 0, 0, 0, 0, 1, 0, 0, "mc_lat0");
        cyc(1, 0, 0, 0, 0, 1, 2, 0, "mc_lat2");
        idle(2, "mc_short_after");

        cyc(1, 0, 0, 0, 0, 1, 5, 0, "mc_lat5_start");
        idle(1, "mc_lat5_wait");
        cyc(1, 0, 0, 0, 1, 0, 0, 0, "mc_dmem");
        cyc(1, 0, 0, 0, 1, 0, 0, 0, "mc_dmem");
        idle(4, "mc_lat5_tail");

        cyc(1, 0, 0, 0, 0, 1, 6, 0, "mc_lat6_start");
        idle(1, "mc_lat6_wait");
        cyc(1, 1, 1, 0, 0, 0, 0, 0, "flush_in_mc");
        idle(3, "flush_tail");

        cyc(1, 0, 1, 0, 0, 0, 0, 0, "redirect_slot0");
        cyc(1, 0, 1, 1, 0, 0, 0, 0, "redirect_slot1");
        cyc(1, 0, 1, 0, 1, 1, 7, 1, "redirect_prio");
        cyc(1, 0, 0, 0, 1, 1, 7, 1, "dmem_prio");
        cyc(1, 0, 0, 0, 1, 0, 0, 0, "dmem_hold");
        idle(1, "dmem_after");

        cyc(1, 1, 0, 0, 0, 0, 0, 0, "flush_start");
        cyc(0, 1, 1, 0, 1, 1, 5, 1, "act_off");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "act_off");
        cyc(1, 0, 1, 0, 1, 0, 0, 1, "flush_resume");
        idle(2, "flush_resume_after");

        cyc(1, 0, 0, 0, 0, 1, 9, 0, "mc_lat9_start");
        idle(2, "mc_lat9_wait");
        rst_cyc("reset_mid_mc");
        idle(3, "after_mid_reset");

        for (int i = 0; i < 900; i++) begin
            cyc(($urandom_range(0, 19) != 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 5) == 0),
                "random");
        end
        idle(2, "drain");

        repeat (3) @(negedge CLK);
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
